// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
package uart_pkg;

    localparam int CLKS_PER_BIT_115200 = 434;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         push_ready,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [AW:0]  count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign valid      = (count_q != '0);
    assign do_pop     = pop && valid;
    assign push_ready = (count_q != FULL) || do_pop;
    assign do_push    = push && push_ready;
    assign dout       = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a show-ahead byte FIFO for the CPU core.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [FIFO_AW:0] fifo_count,
    output logic             is_receiving,
    output logic             overrun,
    output logic             frame_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta_q;
    logic          rxs_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    byte_t         shreg_q, shreg_d;
    logic          overrun_q, overrun_d;
    logic          frame_error_q, frame_error_d;
    logic          push_req;
    logic          push_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        overrun_d     = 1'b0;
        frame_error_d = 1'b0;
        push_req      = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // mid-bit recheck filters glitches shorter than half a bit
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shreg_d   = {rxs_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push_req  = 1'b1;
                        overrun_d = !push_ready;
                        state_d   = RX_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rxs_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rxs_q         <= rx_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    sync_fifo #(
        .W  (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_req),
        .din        (shreg_q),
        .push_ready (push_ready),
        .pop        (rx_ready),
        .dout       (rx_data),
        .valid      (rx_valid),
        .count      (fifo_count)
    );

    assign is_receiving = (state_q != RX_IDLE);
    assign overrun      = overrun_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a shortened bit period.
module tb_uart_rx_fifo;

    localparam int CPB      = 64;
    localparam int FRAME    = 10 * CPB;
    localparam int STOP_LAT = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] fifo_count;
    logic       is_receiving;
    logic       overrun;
    logic       frame_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int ovr_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int recv_cnt = 0;
    logic prev_valid = 1'b0;
    int ovr0, fe0, rec0;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .fifo_count   (fifo_count),
        .is_receiving (is_receiving),
        .overrun      (overrun),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) ovr_cnt++;
            if (frame_error) fe_cnt++;
            if (overrun && frame_error) both_cnt++;
            if (is_receiving) recv_cnt++;
            if (rx_valid && !prev_valid) rise_cyc = cyc;
        end
        prev_valid = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int pop_at, input int ncyc);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        start_cyc = cyc;
        for (int c = 0; c < ncyc; c++) begin
            rx = bits[c / CPB];
            rx_ready = (c == pop_at);
            @(negedge clk);
        end
        rx_ready = 1'b0;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_valid", 32'(rx_valid), 0);
        chk("reset_count", 32'(fifo_count), 0);
        chk("reset_data", 32'(rx_data), 0);
        chk("reset_recv", 32'(is_receiving), 0);
        chk("reset_ovr", 32'(overrun), 0);
        chk("reset_fe", 32'(frame_error), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single frame timing
        ovr0 = ovr_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b1, -1, FRAME);
        chk("t1_latency", 32'(rise_cyc - start_cyc), 32'(STOP_LAT));
        chk("t1_data", 32'(rx_data), 32'h55);
        chk("t1_count", 32'(fifo_count), 1);
        chk("t1_ovr", 32'(ovr_cnt - ovr0), 0);
        chk("t1_fe", 32'(fe_cnt - fe0), 0);
        pop_one();
        chk("t1_empty", 32'(rx_valid), 0);

        // fill to 16, then one overrun
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), 1'b1, -1, FRAME);
        end
        chk("t2_full", 32'(fifo_count), 16);
        chk("t2_no_ovr", 32'(ovr_cnt - ovr0), 0);
        send_frame(8'h10, 1'b1, -1, FRAME);
        chk("t2_ovr", 32'(ovr_cnt - ovr0), 1);
        chk("t2_still_full", 32'(fifo_count), 16);
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", 32'(rx_data), 32'(i));
            @(negedge clk);
        end
        rx_ready = 1'b0;
        chk("t2_empty", 32'(rx_valid), 0);
        chk("t2_count0", 32'(fifo_count), 0);

        // framing error with held-low line
        send_frame(8'hA3, 1'b0, -1, FRAME);
        repeat (2000) @(negedge clk);
        chk("t3_fe", 32'(fe_cnt - fe0), 1);
        chk("t3_break", 32'(is_receiving), 1);
        chk("t3_nopush", 32'(fifo_count), 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3_idle", 32'(is_receiving), 0);
        send_frame(8'h3C, 1'b1, -1, FRAME);
        chk("t3_count", 32'(fifo_count), 1);
        chk("t3_data", 32'(rx_data), 32'h3C);
        chk("t3_fe_once", 32'(fe_cnt - fe0), 1);
        pop_one();

        // start-bit glitch
        rec0 = recv_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("t4_recv_len", 32'(recv_cnt - rec0), 32'(CPB / 2));
        chk("t4_nopush", 32'(fifo_count), 0);
        chk("t4_ovr", 32'(ovr_cnt - ovr0), 1);
        chk("t4_fe", 32'(fe_cnt - fe0), 1);

        // push into full FIFO with simultaneous pop
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(8'h20 + i), 1'b1, -1, FRAME);
        end
        chk("t5_full", 32'(fifo_count), 16);
        send_frame(8'h7E, 1'b1, STOP_LAT - 1, FRAME);
        chk("t5_no_ovr", 32'(ovr_cnt - ovr0), 1);
        chk("t5_count", 32'(fifo_count), 16);
        rx_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk("t5_drain", 32'(rx_data), 32'(8'h21 + i));
            @(negedge clk);
        end
        chk("t5_last", 32'(rx_data), 32'h7E);
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t5_empty", 32'(rx_valid), 0);

        // async reset mid-frame
        send_frame(8'h11, 1'b1, -1, FRAME);
        send_frame(8'h22, 1'b1, -1, FRAME);
        send_frame(8'h33, 1'b1, -1, FRAME);
        chk("t6_count3", 32'(fifo_count), 3);
        send_frame(8'h99, 1'b1, -1, 350);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rx_valid), 0);
        chk("t6_rst_count", 32'(fifo_count), 0);
        chk("t6_rst_data", 32'(rx_data), 0);
        chk("t6_rst_recv", 32'(is_receiving), 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ovr0 = ovr_cnt;
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b1, -1, FRAME);
        chk("t6_count", 32'(fifo_count), 1);
        chk("t6_data", 32'(rx_data), 32'h81);
        chk("t6_pulses", 32'((ovr_cnt - ovr0) + (fe_cnt - fe0)), 0);
        chk("both_pulses", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
